// File: rtl/param_updown_counter.sv
// Loadable up/down counter with a programmable modulus, wrap or saturate mode, and status flags.
// count, wrap and sat update one clock edge after the request; tc is combinational; there is no backpressure.
module param_updown_counter #(
  parameter int unsigned      WIDTH       = 16,
  parameter longint unsigned  MAX_VALUE   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned  RESET_VALUE = 64'd0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_all,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "param_updown_counter: WIDTH must be within 2..32");
  end
  if (MAX_VALUE >= (64'd1 << WIDTH)) begin : g_bad_max
    $fatal(1, "param_updown_counter: MAX_VALUE does not fit in WIDTH bits");
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
    $fatal(1, "param_updown_counter: RESET_VALUE exceeds MAX_VALUE");
  end

  localparam logic [WIDTH-1:0] MAX_W   = MAX_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_W = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MAX_W);
  assign at_zero = (count_q == '0);

  // Limits are tested before the add/subtract, so no carry or borrow is ever needed.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (set_all) begin
      count_d = MAX_W;
      sat_d   = 1'b0;
    end else if (load) begin
      count_d = (load_value > MAX_W) ? MAX_W : load_value;
      sat_d   = 1'b0;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          count_d = count_q + ONE_W;
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - ONE_W;
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = MAX_W;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RESET_W;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;
  assign tc    = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for three counter configurations: 16-bit wrap, modulo-10 wrap, 8-bit saturate.
module tb_param_updown_counter;

  typedef struct {
    int          id;
    string       tag;
    logic [31:0] cnt;
    logic        wrap;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  set_all, load, en, up;
  logic [15:0] a_lv;
  logic [3:0]  b_lv;
  logic [7:0]  c_lv;
  logic [15:0] a_count;
  logic [3:0]  b_count;
  logic [7:0]  c_count;
  logic [2:0]  tc, wrap, sat;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  param_updown_counter u_a (
    .clk(clk), .rst_n(rst_n), .set_all(set_all[0]), .load(load[0]), .load_value(a_lv),
    .en(en[0]), .up(up[0]), .count(a_count), .tc(tc[0]), .wrap(wrap[0]), .sat(sat[0])
  );

  param_updown_counter #(.WIDTH(4), .MAX_VALUE(9)) u_b (
    .clk(clk), .rst_n(rst_n), .set_all(set_all[1]), .load(load[1]), .load_value(b_lv),
    .en(en[1]), .up(up[1]), .count(b_count), .tc(tc[1]), .wrap(wrap[1]), .sat(sat[1])
  );

  param_updown_counter #(.WIDTH(8), .SATURATE(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .set_all(set_all[2]), .load(load[2]), .load_value(c_lv),
    .en(en[2]), .up(up[2]), .count(c_count), .tc(tc[2]), .wrap(wrap[2]), .sat(sat[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic expect_st(input int id, input string tag, input logic [31:0] cnt,
                           input logic w, input logic s);
    exp_t e;
    e.id = id; e.tag = tag; e.cnt = cnt; e.wrap = w; e.sat = s;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t        e;
    logic [31:0] c;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.id)
        0:       c = {16'd0, a_count};
        1:       c = {28'd0, b_count};
        default: c = {24'd0, c_count};
      endcase
      chk({e.tag, ".count"}, c, e.cnt);
      chk({e.tag, ".wrap"}, {31'd0, wrap[e.id]}, {31'd0, e.wrap});
      chk({e.tag, ".sat"}, {31'd0, sat[e.id]}, {31'd0, e.sat});
    end
  endtask

  task automatic chk_tc(input int id, input string tag, input logic expv);
    #1;
    chk(tag, {31'd0, tc[id]}, {31'd0, expv});
  endtask

  initial begin
    logic [31:0] down_seq[5];
    logic [31:0] prev;
    down_seq[0] = 32'h2;    down_seq[1] = 32'h1; down_seq[2] = 32'h0;
    down_seq[3] = 32'hFFFF; down_seq[4] = 32'hFFFE;

    rst_n = 1'b0; set_all = '0; load = '0; en = '0; up = '0;
    a_lv = '0; b_lv = '0; c_lv = '0;
    tick();
    expect_st(0, "rst_a", 0, 0, 0);
    expect_st(1, "rst_b", 0, 0, 0);
    expect_st(2, "rst_c", 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // 16-bit wrap instance: set_all, priority over load, down-count through zero
    set_all[0] = 1'b1;
    expect_st(0, "set_all", 32'hFFFF, 0, 0); tick();
    load[0] = 1'b1; a_lv = 16'h1234;
    expect_st(0, "set_over_load", 32'hFFFF, 0, 0); tick();
    set_all[0] = 1'b0; a_lv = 16'h0003;
    expect_st(0, "load3", 3, 0, 0); tick();
    load[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b0;
    prev = 3;
    for (int i = 0; i < 5; i++) begin
      chk_tc(0, $sformatf("down_tc%0d", i), prev == 0);
      expect_st(0, $sformatf("down%0d", i), down_seq[i], down_seq[i] == 32'hFFFF, 0);
      tick();
      prev = down_seq[i];
    end
    load[0] = 1'b1; a_lv = 16'h0100;
    expect_st(0, "load_over_en", 32'h0100, 0, 0); tick();
    a_lv = 16'h0000;
    expect_st(0, "load0", 0, 0, 0); tick();
    load[0] = 1'b0;
    expect_st(0, "wrap_before_rst", 32'hFFFF, 1, 0); tick();
    rst_n = 1'b0;
    expect_st(0, "rst_mid", 0, 0, 0); tick();
    rst_n = 1'b1; en[0] = 1'b0; load[0] = 1'b1; a_lv = 16'h0007;
    expect_st(0, "load7", 7, 0, 0); tick();
    load[0] = 1'b0; en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up[0] = (i % 2 == 0);
      chk_tc(0, $sformatf("toggle_tc%0d", i), 1'b0);
      expect_st(0, $sformatf("toggle%0d", i), (i % 2 == 0) ? 8 : 7, 0, 0);
      tick();
    end
    en[0] = 1'b0;

    // modulo-10 instance
    load[1] = 1'b1; b_lv = 4'd8;
    expect_st(1, "mod_load8", 8, 0, 0); tick();
    load[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b1;
    chk_tc(1, "mod_tc8", 1'b0);
    expect_st(1, "mod_up9", 9, 0, 0); tick();
    chk_tc(1, "mod_tc9", 1'b1);
    expect_st(1, "mod_wrap0", 0, 1, 0); tick();
    expect_st(1, "mod_up1", 1, 0, 0); tick();
    en[1] = 1'b0;
    expect_st(1, "mod_hold", 1, 0, 0); tick();
    load[1] = 1'b1; b_lv = 4'd15;
    expect_st(1, "mod_clamp", 9, 0, 0); tick();
    load[1] = 1'b0;

    // saturating instance
    load[2] = 1'b1; c_lv = 8'd1;
    expect_st(2, "sat_load1", 1, 0, 0); tick();
    load[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b0;
    expect_st(2, "sat_dn0", 0, 0, 0); tick();
    chk_tc(2, "sat_tc0", 1'b1);
    expect_st(2, "sat_dn1", 0, 0, 1); tick();
    expect_st(2, "sat_dn2", 0, 0, 1); tick();
    up[2] = 1'b1;
    expect_st(2, "sat_up1", 1, 0, 1); tick();
    expect_st(2, "sat_up2", 2, 0, 1); tick();
    load[2] = 1'b1; c_lv = 8'd5;
    expect_st(2, "sat_load5", 5, 0, 0); tick();
    c_lv = 8'hFF;
    expect_st(2, "sat_loadff", 32'hFF, 0, 0); tick();
    load[2] = 1'b0;
    expect_st(2, "sat_top", 32'hFF, 0, 1); tick();
    en[2] = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
